// File: rtl/uart_membus_master.sv
// uart_membus_master: turns 8N1 UART command frames into single 32-bit memory
// bus transactions and returns read data, an acknowledge or an error byte.
module uart_membus_master #(
  parameter int CLKDIV  = 104,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        mem_valid,
  output logic        mem_instr,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        busy
);
  localparam int CW = $clog2(CLKDIV);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKDIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKDIV / 2 - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {P_IDLE, P_ADDR, P_DATA, P_BUS, P_REPLY} p_state_t;

  rx_state_t     rx_state, rx_next;
  logic          rx_meta, rx_sync, rx_prev;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift, rx_byte;
  logic          rx_strobe, rx_ferr, rx_tick;

  p_state_t      state, state_next;
  logic          is_write;
  logic [1:0]    byte_cnt;
  logic [31:0]   addr_sr, data_sr, reply_sr;
  logic [2:0]    reply_left;
  logic [TW-1:0] to_cnt;
  logic          bus_done, bus_timeout;

  logic          tx_busy, tx_done, tx_load;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bitn;
  logic [8:0]    tx_sh;
  logic [7:0]    tx_byte;

  assign mem_instr   = 1'b0;
  assign busy        = (state != P_IDLE);
  assign bus_done    = mem_valid && mem_ready;
  assign bus_timeout = mem_valid && !mem_ready && (to_cnt == TO_LAST);
  assign tx_done     = tx_busy && (tx_cnt == BIT_LAST) && (tx_bitn == 4'd9);

  // Start bit is re-checked half a bit in, then every later sample lands mid-bit.
  always_comb begin
    rx_next = rx_state;
    rx_tick = (rx_state == RX_START) ? (rx_cnt == HALF_LAST) : (rx_cnt == BIT_LAST);
    case (rx_state)
      RX_IDLE:  if (rx_prev && !rx_sync) rx_next = RX_START;
      RX_START: if (rx_tick) rx_next = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (rx_tick) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state  <= RX_IDLE;
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      rx_prev   <= 1'b1;
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_shift  <= '0;
      rx_byte   <= '0;
      rx_strobe <= 1'b0;
      rx_ferr   <= 1'b0;
    end else begin
      rx_state  <= rx_next;
      rx_meta   <= uart_rx;
      rx_sync   <= rx_meta;
      rx_prev   <= rx_sync;
      rx_strobe <= 1'b0;
      rx_ferr   <= 1'b0;
      if (rx_state == RX_IDLE || rx_tick) rx_cnt <= '0;
      else rx_cnt <= rx_cnt + 1'b1;
      if (rx_state == RX_START) rx_bit <= '0;
      if (rx_state == RX_DATA && rx_tick) begin
        rx_shift <= {rx_sync, rx_shift[7:1]};
        rx_bit   <= rx_bit + 1'b1;
      end
      if (rx_state == RX_STOP && rx_tick) begin
        rx_strobe <= rx_sync;
        rx_ferr   <= !rx_sync;
        rx_byte   <= rx_shift;
      end
    end
  end

  // Framing errors only abort a command still being assembled; BUS/REPLY ignore RX.
  always_comb begin
    state_next = state;
    case (state)
      P_IDLE:  if (rx_strobe && (rx_byte == 8'h57 || rx_byte == 8'h52)) state_next = P_ADDR;
      P_ADDR:
        if (rx_ferr) state_next = P_IDLE;
        else if (rx_strobe && byte_cnt == 2'd3) state_next = is_write ? P_DATA : P_BUS;
      P_DATA:
        if (rx_ferr) state_next = P_IDLE;
        else if (rx_strobe && byte_cnt == 2'd3) state_next = P_BUS;
      P_BUS:   if (bus_done || bus_timeout) state_next = P_REPLY;
      P_REPLY: if (tx_done && reply_left == 3'd1) state_next = P_IDLE;
      default: state_next = P_IDLE;
    endcase
  end

  always_comb begin
    tx_load = 1'b0;
    tx_byte = 8'h00;
    if (state == P_BUS && (bus_done || bus_timeout)) begin
      tx_load = 1'b1;
      if (bus_timeout) tx_byte = 8'h45;
      else if (is_write) tx_byte = 8'h4B;
      else tx_byte = mem_rdata[31:24];
    end else if (state == P_REPLY && tx_done && reply_left > 3'd1) begin
      tx_load = 1'b1;
      tx_byte = reply_sr[23:16];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= P_IDLE;
      is_write   <= 1'b0;
      byte_cnt   <= '0;
      addr_sr    <= '0;
      data_sr    <= '0;
      reply_sr   <= '0;
      reply_left <= '0;
      to_cnt     <= '0;
      mem_valid  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
    end else begin
      state <= state_next;
      if (state == P_IDLE) begin
        byte_cnt <= '0;
        if (rx_strobe) is_write <= (rx_byte == 8'h57);
      end
      if (state == P_ADDR && rx_strobe) begin
        addr_sr  <= {addr_sr[23:0], rx_byte};
        byte_cnt <= byte_cnt + 1'b1;
      end
      if (state == P_DATA && rx_strobe) begin
        data_sr  <= {data_sr[23:0], rx_byte};
        byte_cnt <= byte_cnt + 1'b1;
      end
      // The final command byte is still in rx_byte, so splice it in on BUS entry.
      if (state_next == P_BUS && state != P_BUS) begin
        mem_valid <= 1'b1;
        to_cnt    <= '0;
        if (is_write) begin
          mem_addr  <= {addr_sr[31:2], 2'b00};
          mem_wdata <= {data_sr[23:0], rx_byte};
          mem_wstrb <= 4'hF;
        end else begin
          mem_addr  <= {addr_sr[23:0], rx_byte[7:2], 2'b00};
          mem_wstrb <= 4'h0;
        end
      end
      if (state == P_BUS) begin
        if (bus_done || bus_timeout) begin
          mem_valid  <= 1'b0;
          reply_sr   <= mem_rdata;
          reply_left <= (bus_done && !is_write) ? 3'd4 : 3'd1;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
      if (state == P_REPLY && tx_done && reply_left > 3'd1) begin
        reply_sr   <= {reply_sr[23:0], 8'h00};
        reply_left <= reply_left - 1'b1;
      end
    end
  end

  // Loading the next byte on the stop bit's last cycle keeps replies back-to-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_busy <= 1'b0;
      tx_cnt  <= '0;
      tx_bitn <= '0;
      tx_sh   <= '1;
      uart_tx <= 1'b1;
    end else if (tx_load) begin
      tx_busy <= 1'b1;
      tx_cnt  <= '0;
      tx_bitn <= '0;
      tx_sh   <= {1'b1, tx_byte};
      uart_tx <= 1'b0;
    end else if (tx_busy) begin
      if (tx_cnt == BIT_LAST) begin
        tx_cnt <= '0;
        if (tx_bitn == 4'd9) begin
          tx_busy <= 1'b0;
          uart_tx <= 1'b1;
        end else begin
          uart_tx <= tx_sh[0];
          tx_sh   <= {1'b1, tx_sh[8:1]};
          tx_bitn <= tx_bitn + 1'b1;
        end
      end else begin
        tx_cnt <= tx_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_membus_master.sv
// Directed bench for uart_membus_master: UART host driver, reply decoder and a
// programmable memory responder.
module tb_uart_membus_master;
  localparam int CLKDIV  = 8;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uart_rx = 1'b1;
  logic        uart_tx;
  logic        mem_valid;
  logic        mem_instr;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = 32'h0;
  logic        busy;

  int checks = 0;
  int fails  = 0;

  int ready_delay = 0;
  bit idle_noise  = 1'b0;
  int vcnt = 0, last_len = 0, txn_count = 0, stable_err = 0, stop_err = 0;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_wstrb;
  logic [7:0]  rx_q[$];
  int base;

  uart_membus_master #(.CLKDIV(CLKDIV), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .uart_tx(uart_tx),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Responder: ready_delay cycles after mem_valid rises (negative = never).
  always @(negedge clk) begin
    if (mem_valid === 1'b1) begin
      if (vcnt == 0) begin
        txn_count++;
        cap_addr  = mem_addr;
        cap_wdata = mem_wdata;
        cap_wstrb = mem_wstrb;
      end else if (mem_addr !== cap_addr || mem_wdata !== cap_wdata || mem_wstrb !== cap_wstrb) begin
        stable_err++;
      end
      mem_ready = (ready_delay >= 0) && (vcnt == ready_delay);
      vcnt++;
    end else begin
      if (vcnt != 0) last_len = vcnt;
      vcnt = 0;
      mem_ready = idle_noise;
    end
  end

  initial begin : tx_monitor
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (uart_tx === 1'b0 && rst === 1'b0) begin
        repeat (CLKDIV / 2) @(negedge clk);
        if (uart_tx === 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            repeat (CLKDIV) @(negedge clk);
            b[i] = uart_tx;
          end
          repeat (CLKDIV) @(negedge clk);
          if (uart_tx === 1'b1) rx_q.push_back(b);
          else stop_err++;
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (CLKDIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = data[i];
      repeat (CLKDIV) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (CLKDIV) @(negedge clk);
    uart_rx = 1'b1;
    repeat (CLKDIV) @(negedge clk);
  endtask

  task automatic applyCommand(input logic [71:0] cmd, input int n);
    for (int i = 0; i < n; i++) applyStimulus(cmd[8*(n-1-i) +: 8], 1'b1);
  endtask

  task automatic waitBytes(input string tag, input int n, input int budget);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    checkOutput(tag, rx_q.size(), n);
  endtask

  task automatic popCheck(input string tag, input logic [7:0] expected);
    logic [7:0] b = 8'hxx;
    if (rx_q.size() > 0) b = rx_q.pop_front();
    checkOutput(tag, {24'h0, b}, {24'h0, expected});
  endtask

  task automatic waitValid(input string tag, input int budget);
    int k = 0;
    while (mem_valid !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    checkOutput(tag, {31'h0, mem_valid}, 32'h1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("rst_uart_tx", {31'h0, uart_tx}, 32'h1);
    checkOutput("rst_mem_valid", {31'h0, mem_valid}, 32'h0);
    checkOutput("rst_mem_instr", {31'h0, mem_instr}, 32'h0);
    checkOutput("rst_mem_addr", mem_addr, 32'h0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
    checkOutput("rst_mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
    checkOutput("rst_busy", {31'h0, busy}, 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] write with zero-wait responder");
    ready_delay = 0;
    base = txn_count;
    applyStimulus(8'h57, 1'b1);
    checkOutput("wr_busy_after_cmd", {31'h0, busy}, 32'h1);
    applyCommand(72'h00_00_01_00_DE_AD_BE_EF, 8);
    waitBytes("wr_reply_count", 1, 40 * CLKDIV);
    popCheck("wr_reply", 8'h4B);
    checkOutput("wr_txn_count", txn_count - base, 1);
    checkOutput("wr_addr", cap_addr, 32'h0000_0100);
    checkOutput("wr_wdata", cap_wdata, 32'hDEAD_BEEF);
    checkOutput("wr_wstrb", {28'h0, cap_wstrb}, 32'hF);
    checkOutput("wr_valid_len", last_len, 1);
    repeat (2 * CLKDIV) @(negedge clk);
    checkOutput("wr_busy_done", {31'h0, busy}, 32'h0);

    $display("[TB] read with 5 wait states and idle ready noise");
    ready_delay = 5;
    idle_noise  = 1'b1;
    mem_rdata   = 32'h1234_5678;
    base = txn_count;
    applyCommand(72'h52_00_00_00_08, 5);
    waitBytes("rd_reply_count", 4, 80 * CLKDIV);
    popCheck("rd_byte0", 8'h12);
    popCheck("rd_byte1", 8'h34);
    popCheck("rd_byte2", 8'h56);
    popCheck("rd_byte3", 8'h78);
    checkOutput("rd_txn_count", txn_count - base, 1);
    checkOutput("rd_valid_len", last_len, 6);
    checkOutput("rd_wstrb", {28'h0, cap_wstrb}, 32'h0);
    checkOutput("rd_addr", cap_addr, 32'h0000_0008);
    repeat (2 * CLKDIV) @(negedge clk);
    checkOutput("rd_busy_done", {31'h0, busy}, 32'h0);
    checkOutput("rd_noise_no_txn", txn_count - base, 1);
    idle_noise = 1'b0;

    $display("[TB] garbage byte then unaligned read");
    ready_delay = 0;
    mem_rdata   = 32'hCAFE_F00D;
    base = txn_count;
    applyStimulus(8'hA5, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("garbage_busy", {31'h0, busy}, 32'h0);
    checkOutput("garbage_no_reply", rx_q.size(), 0);
    applyCommand(72'h52_00_00_00_0B, 5);
    waitBytes("ua_reply_count", 4, 80 * CLKDIV);
    popCheck("ua_byte0", 8'hCA);
    popCheck("ua_byte1", 8'hFE);
    popCheck("ua_byte2", 8'hF0);
    popCheck("ua_byte3", 8'h0D);
    checkOutput("ua_addr", cap_addr, 32'h0000_0008);
    checkOutput("ua_txn_count", txn_count - base, 1);
    repeat (2 * CLKDIV) @(negedge clk);

    $display("[TB] read timeout");
    ready_delay = -1;
    base = txn_count;
    applyCommand(72'h52_00_00_00_20, 5);
    waitBytes("to_reply_count", 1, 60 * CLKDIV);
    popCheck("to_reply", 8'h45);
    checkOutput("to_valid_len", last_len, TIMEOUT);
    checkOutput("to_txn_count", txn_count - base, 1);
    repeat (40 * CLKDIV) @(negedge clk);
    checkOutput("to_no_extra_bytes", rx_q.size(), 0);
    checkOutput("to_busy_done", {31'h0, busy}, 32'h0);

    $display("[TB] framing error inside a write command");
    ready_delay = 0;
    base = txn_count;
    applyStimulus(8'h57, 1'b1);
    applyStimulus(8'h3C, 1'b0);
    checkOutput("fe_busy_cleared", {31'h0, busy}, 32'h0);
    applyCommand(72'h57_00_00_02_00_11_22_33_44, 9);
    waitBytes("fe_reply_count", 1, 40 * CLKDIV);
    popCheck("fe_reply", 8'h4B);
    checkOutput("fe_txn_count", txn_count - base, 1);
    checkOutput("fe_addr", cap_addr, 32'h0000_0200);
    checkOutput("fe_wdata", cap_wdata, 32'h1122_3344);
    repeat (2 * CLKDIV) @(negedge clk);

    $display("[TB] reset during bus phase");
    ready_delay = -1;
    applyCommand(72'h52_00_00_00_04, 5);
    waitValid("rb_valid_seen", 4 * CLKDIV);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rb_valid_dropped", {31'h0, mem_valid}, 32'h0);
    checkOutput("rb_uart_tx_idle", {31'h0, uart_tx}, 32'h1);
    checkOutput("rb_busy_cleared", {31'h0, busy}, 32'h0);
    rst = 1'b0;
    repeat (20 * CLKDIV) @(negedge clk);
    checkOutput("rb_no_reply", rx_q.size(), 0);
    ready_delay = 0;
    base = txn_count;
    applyCommand(72'h57_00_00_00_40_A5_5A_00_FF, 9);
    waitBytes("rb_next_reply_count", 1, 40 * CLKDIV);
    popCheck("rb_next_reply", 8'h4B);
    checkOutput("rb_next_addr", cap_addr, 32'h0000_0040);
    checkOutput("rb_next_wdata", cap_wdata, 32'hA55A_00FF);
    checkOutput("rb_next_txn_count", txn_count - base, 1);
    repeat (2 * CLKDIV) @(negedge clk);

    checkOutput("bus_stable_during_valid", stable_err, 0);
    checkOutput("reply_stop_bits", stop_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/uart_membus_master.md
# uart_membus_master

Serial debug/loader initiator for the native memory bus: receives 8N1 UART command frames from a host, issues single 32-bit read or write transactions on the valid/ready memory bus (the same bus the CPU drives), and returns read data or an acknowledge over UART TX. It sits beside the CPU as a second bus initiator, behind the SoC's bus arbiter, and lets a host load firmware into RAM or poke IO (e.g. the LED register) without the CPU.

## Interface
Parameters:
- CLKDIV, 104: clock cycles per UART bit (minimum 4).
- TIMEOUT, 1024: cycles to wait for mem_ready before abandoning a transaction (minimum 2).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- uart_rx  input  1  asynchronous serial in, idle high.
- uart_tx  output  1  serial out, idle high.
- mem_valid  output  1  transaction request.
- mem_instr  output  1  constant 0.
- mem_ready  input  1  responder completion strobe.
- mem_addr  output  32  word address; bits [1:0] always 0.
- mem_wdata  output  32  write data.
- mem_wstrb  output  4  4'b1111 for writes, 4'b0000 for reads.
- mem_rdata  input  32  read data, valid in the mem_ready cycle.
- busy  output  1  high from first command byte accepted to last reply stop bit sent.

## Operation
- RX: rx passes through a 2-flop synchronizer. Falling edge in idle starts a frame; start bit re-checked at CLKDIV/2; data bits sampled LSB-first every CLKDIV from there; stop bit sampled. Stop=0 → framing error: byte discarded, parser returns to IDLE.
- Commands (multi-byte fields big-endian):
  - 0x57 'W', A3..A0, D3..D0 → write; reply 0x4B 'K'.
  - 0x52 'R', A3..A0 → read; reply 4 bytes of mem_rdata, MSB first.
  - Any other byte in IDLE ignored; busy stays 0.
- Parser FSM: IDLE → ADDR (4 bytes) → DATA (4 bytes, writes only) → BUS → REPLY → IDLE.
- BUS: mem_valid=1 with addr/wdata/wstrb held stable until the cycle mem_ready=1 is sampled; mem_valid drops the next cycle. Read data latched in that same cycle.
- Timeout: a counter starts on mem_valid rise. If TIMEOUT cycles pass without mem_ready, mem_valid drops and the reply is a single 0x45 'E'. A read that times out sends no data bytes.
- Received address bits [1:0] are forced to 0 on mem_addr.
- Bytes arriving during BUS or REPLY are discarded; RX keeps decoding so that it stays in frame sync.
- TX: 8N1, LSB-first, CLKDIV cycles per bit. Reply bytes are sent back-to-back, with no idle between stop and the next start.

## Timing
- Reset values: uart_tx=1, mem_valid=0, mem_instr=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, busy=0. The FSM, RX, TX and all counters return to idle.
- A reset mid-transaction drops mem_valid on the next edge. A reset mid-TX forces uart_tx=1 immediately after the reset edge.
- RX byte strobe: asserted one cycle after the stop-bit sample point.
- mem_valid rises 1 cycle after the strobe of the final command byte.
- mem_ready may be high in the same cycle that mem_valid rises. That cycle is the completion (zero-wait responder). mem_ready while mem_valid=0 is ignored.
- Reply start bit begins 1 cycle after the mem_ready or timeout cycle.
- busy falls 1 cycle after the final reply stop bit completes.
- Each command is at most one bus transaction. No overlap and no pipelining.

## Test plan
- Write: send 57 00 00 01 00 DE AD BE EF with a 0-wait responder → one mem_valid pulse with addr 0x00000100, wdata 0xDEADBEEF, wstrb 1111; uart_tx returns 0x4B.
- Read with wait states: send 52 00 00 00 08; responder asserts mem_ready 5 cycles after mem_valid with rdata 0x12345678 → mem_valid high exactly 6 cycles, wstrb 0000; reply bytes 12 34 56 78.
- Unaligned/garbage: send 0xA5, then 52 00 00 00 0B → 0xA5 ignored with busy=0; mem_addr=0x00000008.
- Timeout: TIMEOUT=16, responder never ready, read command → mem_valid high 16 cycles then 0; reply is the single byte 0x45.
- Framing error: send 57, then a byte with stop bit 0, then a valid write command → no transaction from the corrupted frame; the subsequent write completes with reply 0x4B.
- Reset mid-BUS: assert rst while mem_valid=1 → mem_valid=0 and uart_tx=1 next cycle; no reply sent; the next command works normally.
